uart_tx_engine: RTL and testbench

//  Serial UART transmitter: accepts a parallel word over a valid/ready handshake and

---
 rtl/uart_tx_engine.sv | 115 +++++++++++
 tb/tb_uart_tx_engine.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: LSB-first UART transmitter (start/data/parity/stop) with valid/ready input and per-frame latched bit divider.
module uart_tx_engine #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 tx
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx_engine: illegal parameter combination");
  end
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     timer_q, timer_d, div_q, div_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 par_q, par_d, tx_q, tx_d, tx_ready_q, tx_ready_d, tx_done_q, tx_done_d;
  logic                 bit_end;
  assign bit_end = timer_q == div_q;
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_d      = div_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    tx_done_d  = 1'b0;
    if (state_q == IDLE) begin
      tx_d       = 1'b1;
      tx_ready_d = 1'b1;
      if (tx_valid && tx_ready_q) begin
        state_d    = START;
        tx_d       = 1'b0;
        tx_ready_d = 1'b0;
        timer_d    = '0;
        div_d      = clk_div;
        shift_d    = tx_data;
        par_d      = (PARITY == 2) ? ~^tx_data : ^tx_data;
      end
    end else begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          START: begin
            state_d = DATA;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = '0;
          end
          DATA: begin
            if (cnt_q == LAST_DATA) begin
              state_d = (PARITY != 0) ? PAR : STOP;
              tx_d    = (PARITY != 0) ? par_q : 1'b1;
              cnt_d   = '0;
            end else begin
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
              cnt_d   = cnt_q + 4'd1;
            end
          end
          PAR: begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
          default: cnt_d = cnt_q + 4'd1;
        endcase
      end
      // The final stop-bit cycle is spent in IDLE so ready and done line up with it.
      if (state_d == STOP && cnt_d == LAST_STOP && timer_d == div_q) begin
        state_d    = IDLE;
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
        tx_done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
    end
  end
  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_done  = tx_done_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed and random frames on four configurations, checked cycle by cycle against a frame-level model.
module tb_uart_tx_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] clk_div = '0;
  logic        valid = 1'b0;
  logic [8:0]  data = '0;
  int          sel = 0;
  logic [3:0]  txs, rdys, dones;
  int          errors = 0;
  int          checks = 0;
  int          cfg_nb [4] = '{8, 8, 8, 7};
  int          cfg_par[4] = '{0, 1, 2, 0};
  int          cfg_stp[4] = '{1, 1, 1, 2};
  always #5 clk = ~clk;
  uart_tx_engine u0 (.clk(clk), .reset(reset), .clk_div(clk_div), .tx_valid(valid && sel == 0),
                     .tx_data(data[7:0]), .tx_ready(rdys[0]), .tx_done(dones[0]), .tx(txs[0]));
  uart_tx_engine #(.PARITY(1)) u1 (.clk(clk), .reset(reset), .clk_div(clk_div), .tx_valid(valid && sel == 1),
                     .tx_data(data[7:0]), .tx_ready(rdys[1]), .tx_done(dones[1]), .tx(txs[1]));
  uart_tx_engine #(.PARITY(2)) u2 (.clk(clk), .reset(reset), .clk_div(clk_div), .tx_valid(valid && sel == 2),
                     .tx_data(data[7:0]), .tx_ready(rdys[2]), .tx_done(dones[2]), .tx(txs[2]));
  uart_tx_engine #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.clk(clk), .reset(reset), .clk_div(clk_div), .tx_valid(valid && sel == 3),
                     .tx_data(data[6:0]), .tx_ready(rdys[3]), .tx_done(dones[3]), .tx(txs[3]));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Starts from a cycle where the selected engine shows ready; ends in the frame's tx_done cycle.
  task automatic send(input int s, input logic [8:0] w, input int div, input bit hold, input int chg_at, input int new_div);
    bit fb[16];
    int nbits;
    int ones;
    int n;
    nbits = 1;
    fb[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < cfg_nb[s]; i++) begin
      fb[nbits] = w[i];
      nbits++;
      ones += int'(w[i]);
    end
    if (cfg_par[s] != 0) begin
      fb[nbits] = (cfg_par[s] == 1) ? bit'(ones % 2) : bit'(1 - ones % 2);
      nbits++;
    end
    for (int i = 0; i < cfg_stp[s]; i++) begin
      fb[nbits] = 1'b1;
      nbits++;
    end
    n = nbits * (div + 1);
    sel = s;
    clk_div = 16'(div);
    data = w;
    valid = 1'b1;
    step;
    if (!hold) valid = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (c == chg_at) begin
        clk_div = 16'(new_div);
        data = ~w;
      end
      chk($sformatf("tx s%0d w%0h c%0d", s, w, c), 32'(txs[s]), 32'(fb[(c - 1) / (div + 1)]));
      chk($sformatf("ready s%0d c%0d", s, c), 32'(rdys[s]), 32'(c == n));
      chk($sformatf("done s%0d c%0d", s, c), 32'(dones[s]), 32'(c == n));
      if (c < n) step;
    end
  endtask
  task automatic idle_check(input int s);
    step;
    chk($sformatf("idle tx s%0d", s), 32'(txs[s]), 32'd1);
    chk($sformatf("idle ready s%0d", s), 32'(rdys[s]), 32'd1);
    chk($sformatf("idle done s%0d", s), 32'(dones[s]), 32'd0);
  endtask
  initial begin
    repeat (3) step;
    chk("reset tx", 32'(txs), 32'hF);
    chk("reset ready", 32'(rdys), 32'h0);
    chk("reset done", 32'(dones), 32'h0);
    reset = 1'b0;
    step;
    chk("post-reset ready", 32'(rdys), 32'hF);
    chk("post-reset tx", 32'(txs), 32'hF);
    send(0, 9'h055, 3, 1'b0, 0, 0);
    idle_check(0);
    send(1, 9'h007, 2, 1'b0, 0, 0);
    idle_check(1);
    send(2, 9'h007, 1, 1'b0, 0, 0);
    idle_check(2);
    send(0, 9'h0A5, 0, 1'b1, 0, 0);
    send(0, 9'h03C, 0, 1'b0, 0, 0);
    idle_check(0);
    sel = 0;
    clk_div = 16'd1;
    data = 9'h000;
    valid = 1'b1;
    step;
    valid = 1'b0;
    repeat (8) step;
    chk("pre-reset tx bit4", 32'(txs[0]), 32'd0);
    reset = 1'b1;
    step;
    chk("abort tx", 32'(txs[0]), 32'd1);
    chk("abort ready", 32'(rdys[0]), 32'd0);
    chk("abort done", 32'(dones[0]), 32'd0);
    step;
    chk("abort done hold", 32'(dones[0]), 32'd0);
    reset = 1'b0;
    step;
    chk("release ready", 32'(rdys[0]), 32'd1);
    chk("release done", 32'(dones[0]), 32'd0);
    send(0, 9'h0FF, 1, 1'b0, 0, 0);
    idle_check(0);
    send(0, 9'h0C3, 2, 1'b0, 7, 0);
    send(0, 9'h0C3, 0, 1'b0, 0, 0);
    idle_check(0);
    send(3, 9'h07F, 1, 1'b0, 0, 0);
    idle_check(3);
    for (int k = 0; k < 10; k++) begin
      int s;
      int d;
      logic [8:0] w;
      s = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 3));
      w = 9'($urandom);
      send(s, w, d, 1'b0, 0, 0);
      idle_check(s);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
